// File: rtl/design1_resp_capture.sv
// design1_resp_capture: captures design1 core responses, flags masked mismatches, buffers {mismatch, resp, seq} in a FIFO and keeps error counters; optional MISR under `RESP_MISR_EN
module design1_resp_capture #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       resp,
  input  logic [7:0]       exp_data,
  input  logic [7:0]       exp_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_resp,
  output logic             out_mismatch,
  output logic [SEQ_W-1:0] out_seq,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky,
  output logic [15:0]      signature
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [SEQ_W-1:0] seq;
  logic [7:0]       mem_resp [DEPTH];
  logic             mem_mis  [DEPTH];
  logic [SEQ_W-1:0] mem_seq  [DEPTH];
  logic             push, pop, mismatch, flush;
  assign flush     = !rst_n || clr;
  assign in_ready  = count != (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign mismatch  = |((resp ^ exp_data) & exp_mask);
  assign out_resp     = out_valid ? mem_resp[rd_ptr] : '0;
  assign out_mismatch = out_valid && mem_mis[rd_ptr];
  assign out_seq      = out_valid ? mem_seq[rd_ptr] : '0;
  // storage write on every accepted push; contents are only visible through valid-gated head outputs
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_resp[wr_ptr] <= resp;
      mem_mis[wr_ptr]  <= mismatch;
      mem_seq[wr_ptr]  <= seq;
    end
  end
  // pointers, occupancy, sequence tag and error tracking; reset and clr both flush everything
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      seq        <= '0;
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count      <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      seq        <= push ? seq + 1'b1 : seq;
      err_count  <= (push && mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;
      err_sticky <= err_sticky || (push && mismatch);
    end
  end
`ifdef RESP_MISR_EN
  logic [15:0] sig;
  // CRC-16-CCITT style MISR folding each accepted response into the low byte
  always_ff @(posedge clk) begin
    if (flush) sig <= 16'hFFFF;
    else if (push) sig <= ({sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000)) ^ {8'h00, resp};
  end
  assign signature = sig;
`else
  assign signature = 16'h0000;
`endif
endmodule

// File: tb/tb_design1_resp_capture.sv
// tb_design1_resp_capture: directed self-checking bench for design1_resp_capture
module tb_design1_resp_capture;
  logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  resp = '0, exp_data = '0, exp_mask = '0;
  logic        in_ready, out_valid, out_mismatch, err_sticky;
  logic [7:0]  out_resp, out_seq, err_count;
  logic [15:0] signature;
  int errors = 0, checks = 0;
`ifdef RESP_MISR_EN
  localparam logic [15:0] SIG_RST = 16'hFFFF;
  localparam logic [15:0] SIG_01  = 16'hEFDE;
`else
  localparam logic [15:0] SIG_RST = 16'h0000;
  localparam logic [15:0] SIG_01  = 16'h0000;
`endif
  logic [7:0]  mq_seq[$];
  logic [7:0]  m_seq;
  logic [15:0] m_sig;

  design1_resp_capture dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .resp(resp), .exp_data(exp_data), .exp_mask(exp_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_resp(out_resp), .out_mismatch(out_mismatch), .out_seq(out_seq),
    .err_count(err_count), .err_sticky(err_sticky), .signature(signature)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] r);
    return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {8'h00, r};
  endfunction

  task automatic tick();
    bit p, o;
    if (!rst_n || clr) begin
      mq_seq.delete();
      m_seq = '0;
      m_sig = SIG_RST;
    end else begin
      o = out_ready && mq_seq.size() != 0;
      p = in_valid && mq_seq.size() != 4;
      if (o) void'(mq_seq.pop_front());
      if (p) begin
        mq_seq.push_back(m_seq);
        m_seq++;
`ifdef RESP_MISR_EN
        m_sig = misr(m_sig, resp);
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] r, input logic [7:0] e, input logic [7:0] m);
    in_valid = v; resp = r; exp_data = e; exp_mask = m;
  endtask

  task automatic test_reset();
    set_in(1'b1, 8'h33, 8'h00, 8'hFF);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    set_in(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_resp !== 8'h00 || out_seq !== 8'h00 || out_mismatch !== 1'b0) begin errors++; $display("FAIL reset_head got=%h/%h/%b exp=00/00/0", out_resp, out_seq, out_mismatch); end
    checks++; if (err_count !== 8'h00 || err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err got=%h/%b exp=00/0", err_count, err_sticky); end
    checks++; if (signature !== SIG_RST) begin errors++; $display("FAIL reset_sig got=%h exp=%h", signature, SIG_RST); end
  endtask

  task automatic test_basic();
    set_in(1'b1, 8'hA5, 8'hA5, 8'hFF);
    tick();
    set_in(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (out_valid !== 1'b1 || out_resp !== 8'hA5) begin errors++; $display("FAIL basic_head got=%b/%h exp=1/a5", out_valid, out_resp); end
    checks++; if (out_mismatch !== 1'b0 || out_seq !== 8'h00 || err_count !== 8'h00) begin errors++; $display("FAIL basic_tag got=%b/%h/%h exp=0/00/00", out_mismatch, out_seq, err_count); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got=%b exp=0", out_valid); end
  endtask

  task automatic test_mask();
    set_in(1'b1, 8'h0F, 8'h00, 8'hF0);
    tick();
    set_in(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (out_mismatch !== 1'b0 || out_seq !== 8'h01 || err_sticky !== 1'b0) begin errors++; $display("FAIL mask_dontcare got=%b/%h/%b exp=0/01/0", out_mismatch, out_seq, err_sticky); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    set_in(1'b1, 8'h0F, 8'h00, 8'h01);
    tick();
    set_in(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (out_mismatch !== 1'b1 || out_seq !== 8'h02 || out_resp !== 8'h0F) begin errors++; $display("FAIL mask_hit got=%b/%h/%h exp=1/02/0f", out_mismatch, out_seq, out_resp); end
    checks++; if (err_count !== 8'h01 || err_sticky !== 1'b1) begin errors++; $display("FAIL mask_err got=%h/%b exp=01/1", err_count, err_sticky); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 8'h10 + 8'(i), 8'h10 + 8'(i), 8'hFF);
      tick();
      checks++; if (in_ready !== (i < 3)) begin errors++; $display("FAIL full_ready[%0d] got=%b exp=%b", i, in_ready, i < 3); end
    end
    set_in(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (out_resp !== 8'h10 || out_seq !== 8'h03) begin errors++; $display("FAIL full_hold got=%h/%h exp=10/03", out_resp, out_seq); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_seq !== 8'(3 + i) || out_resp !== 8'(8'h10 + i) || out_mismatch !== 1'b0) begin errors++; $display("FAIL full_drain[%0d] got=%b/%h/%h exp=1/%h/%h", i, out_valid, out_seq, out_resp, 8'(3 + i), 8'(8'h10 + i)); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL full_empty got=%b/%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    bit saw_wrap = 0;
    logic [7:0] prev;
    set_in(1'b1, 8'h5A, 8'h5A, 8'hFF);
    tick(); tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_seq !== 8'(7 + i) || in_ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d] got=%h/%b exp=%h/1", i, out_seq, in_ready, 8'(7 + i)); end
      tick();
    end
    checks++; if (out_seq !== 8'd17) begin errors++; $display("FAIL b2b_end got=%h exp=11", out_seq); end
    prev = out_seq;
    for (int i = 0; i < 300; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_seq !== mq_seq[0]) begin errors++; $display("FAIL wrap[%0d] got=%b/%h exp=1/%h", i, out_valid, out_seq, mq_seq[0]); end
      if (prev == 8'hFF && out_seq == 8'h00) saw_wrap = 1;
      prev = out_seq;
    end
    checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_seen got=0 exp=1"); end
    set_in(1'b0, 8'h00, 8'h00, 8'h00);
    tick(); tick(); tick();
    out_ready = 1'b0;
  endtask

  task automatic test_saturate_clr();
    out_ready = 1'b1;
    set_in(1'b1, 8'hFF, 8'h00, 8'hFF);
    for (int i = 0; i < 100; i++) tick();
    checks++; if (err_count !== 8'd101) begin errors++; $display("FAIL sat_mid got=%h exp=65", err_count); end
    for (int i = 0; i < 200; i++) tick();
    checks++; if (err_count !== 8'hFF || err_sticky !== 1'b1) begin errors++; $display("FAIL sat_end got=%h/%b exp=ff/1", err_count, err_sticky); end
    out_ready = 1'b0;
    set_in(1'b1, 8'h3C, 8'h00, 8'hFF);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    set_in(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clr_fifo got=%b/%b exp=0/1", out_valid, in_ready); end
    checks++; if (err_count !== 8'h00 || err_sticky !== 1'b0 || signature !== SIG_RST) begin errors++; $display("FAIL clr_err got=%h/%b/%h exp=00/0/%h", err_count, err_sticky, signature, SIG_RST); end
    set_in(1'b1, 8'h77, 8'h77, 8'hFF);
    tick();
    set_in(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (out_seq !== 8'h00 || out_resp !== 8'h77) begin errors++; $display("FAIL clr_seq got=%h/%h exp=00/77", out_seq, out_resp); end
  endtask

  task automatic test_misr();
    set_in(1'b1, 8'h44, 8'h44, 8'hFF);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_in(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (out_valid !== 1'b0 || out_resp !== 8'h00 || signature !== SIG_RST) begin errors++; $display("FAIL rst_mid got=%b/%h/%h exp=0/00/%h", out_valid, out_resp, signature, SIG_RST); end
    set_in(1'b1, 8'h01, 8'h00, 8'hFF);
    tick();
    checks++; if (signature !== SIG_01) begin errors++; $display("FAIL misr_first got=%h exp=%h", signature, SIG_01); end
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_in(1'b1, 8'(i * 37 + 5), 8'(i * 11), 8'(i * 91));
      tick();
    end
    set_in(1'b0, 8'h00, 8'h00, 8'h00);
    checks++; if (signature !== m_sig) begin errors++; $display("FAIL misr_16 got=%h exp=%h", signature, m_sig); end
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_full();
    test_back_to_back();
    test_saturate_clr();
    test_misr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
